// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    // Default sequential PC increment (one 32-bit instruction).
    localparam int unsigned PC_STEP_DEFAULT = 4;

    // Fetch control states:
    // ISSUE - a request goes out this cycle (unless redirected)
    // WAIT  - one request outstanding, waiting for its response
    // HOLD  - output buffer full, waiting for decode to accept
    // DRAIN - a squashed request is still outstanding; its response is dropped
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, keeps a single request in
// flight to instruction memory and hands each returned instruction to decode
// through a one-entry valid/ready buffer. Redirects from execute squash any
// in-flight or buffered instruction.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned PC_STEP      = PC_STEP_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_BITS-1:0] redirect_PC,
    output logic                    imem_req,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic                    imem_rvalid,
    input  logic [DATA_WIDTH-1:0]   imem_rdata,
    output logic                    inst_valid,
    output logic [DATA_WIDTH-1:0]   inst,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    input  logic                    inst_ready,
    output logic [ADDRESS_BITS-1:0] PC
);

    fetch_state_e            state_q, state_d;
    logic [ADDRESS_BITS-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   inst_q, inst_d;
    logic [ADDRESS_BITS-1:0] inst_pc_q, inst_pc_d;
    logic                    inst_valid_q, inst_valid_d;

    // Register all fetch state; synchronous reset returns to a clean ISSUE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ISSUE;
            pc_q         <= ADDRESS_BITS'(RESET_PC);
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Next-state logic; a redirect always takes priority over sequential
    // progress, and stray responses outside WAIT/DRAIN leave state untouched.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        unique case (state_q)
            ISSUE: begin
                if (redirect_valid) begin
                    pc_d = redirect_PC;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_PC;
                    state_d = imem_rvalid ? ISSUE : DRAIN;
                end else if (imem_rvalid) begin
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + ADDRESS_BITS'(PC_STEP);
                    state_d      = HOLD;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_PC;
                end
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    pc_d         = redirect_PC;
                    state_d      = ISSUE;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = ISSUE;
                end
            end
            default: begin
                state_d = ISSUE;
            end
        endcase
    end

    assign imem_req   = (state_q == ISSUE) && !redirect_valid && !reset;
    assign imem_addr  = pc_q;
    assign PC         = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_PC    = inst_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer. A transaction-level model
// tracks the architectural fetch address, whether a request is in flight and
// whether it is still wanted, and whether an instruction is buffered; it
// pushes expected requests and instructions into queues that an independent
// monitor pops against what the DUT presents.
module tb_fetch_sequencer;

    localparam int unsigned AB = 16;
    localparam int unsigned DW = 32;
    localparam logic [AB-1:0] RESET_PC_VAL = 16'h0000;

    typedef struct packed {
        logic [AB-1:0] addr;
        logic [DW-1:0] data;
    } inst_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          redirectValid;
    logic [AB-1:0] redirectPc;
    logic          imemReq;
    logic [AB-1:0] imemAddr;
    logic          imemRvalid;
    logic [DW-1:0] imemRdata;
    logic          instValid;
    logic [DW-1:0] instData;
    logic [AB-1:0] instPc;
    logic          instReady;
    logic [AB-1:0] pcOut;

    fetch_sequencer #(
        .ADDRESS_BITS(AB),
        .DATA_WIDTH  (DW),
        .RESET_PC    (0),
        .PC_STEP     (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .redirect_valid(redirectValid),
        .redirect_PC   (redirectPc),
        .imem_req      (imemReq),
        .imem_addr     (imemAddr),
        .imem_rvalid   (imemRvalid),
        .imem_rdata    (imemRdata),
        .inst_valid    (instValid),
        .inst          (instData),
        .inst_PC       (instPc),
        .inst_ready    (instReady),
        .PC            (pcOut)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int handshakes = 0;
    int modelHandshakes = 0;

    // Reference model state.
    bit            mOutstanding = 1'b0;
    bit            mLive = 1'b0;
    bit            mBuffered = 1'b0;
    logic [AB-1:0] mExpPc = RESET_PC_VAL;
    logic [AB-1:0] mReqAddr = '0;

    // Per-cycle expectations handed to the monitor.
    logic [AB-1:0] expPcNow = RESET_PC_VAL;
    bit            expValidNow = 1'b0;
    logic [AB-1:0] reqQ[$];
    inst_t         instQ[$];

    // Memory responder state.
    int            memCount = 0;
    logic [DW-1:0] memData = '0;

    // Stimulus knobs.
    int            cfgRedirPct = 0;
    int            cfgMaxLat = 1;
    int            cfgReadyPct = 100;
    int            cfgSpurPct = 0;
    bit            cfgForceRedirect = 1'b0;
    logic [AB-1:0] cfgForceTarget = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, publish this cycle's expectations, then
    // advance the model once the monitor has looked at the DUT.
    task automatic applyStimulus(input bit doReset);
        logic          rd;
        logic [AB-1:0] rt;
        logic          rv;
        logic [DW-1:0] rdata;
        logic          rdy;
        @(negedge clock);
        rd = !doReset && (cfgForceRedirect || ($urandom_range(99) < cfgRedirPct));
        if (cfgForceRedirect) begin
            rt = cfgForceTarget;
            cfgForceRedirect = 1'b0;
        end else begin
            case ($urandom_range(3))
                0:       rt = 16'hFFFC;
                1:       rt = 16'h0051;
                default: rt = AB'($urandom);
            endcase
        end
        rdy = !doReset && ($urandom_range(99) < cfgReadyPct);
        rv = 1'b0;
        rdata = $urandom;
        if (doReset) begin
            memCount = 0;
        end else if (memCount == 1) begin
            rv = 1'b1;
            rdata = memData;
            memCount = 0;
        end else if (memCount > 1) begin
            memCount--;
        end else if (!mOutstanding && ($urandom_range(99) < cfgSpurPct)) begin
            rv = 1'b1;
        end
        reset = doReset;
        redirectValid = rd;
        redirectPc = rt;
        imemRvalid = rv;
        imemRdata = rdata;
        instReady = rdy;

        expPcNow = mExpPc;
        expValidNow = mBuffered;
        if (!doReset && !mOutstanding && !mBuffered && !rd) begin
            reqQ.push_back(mExpPc);
        end

        #2;
        if (doReset) begin
            mOutstanding = 1'b0;
            mLive = 1'b0;
            mBuffered = 1'b0;
            instQ.delete();
            mExpPc = RESET_PC_VAL;
        end else if (rd) begin
            mExpPc = rt;
            if (mOutstanding) begin
                mLive = 1'b0;
                if (rv) mOutstanding = 1'b0;
            end
            if (mBuffered) begin
                if (rdy) modelHandshakes++;
                else instQ.delete();
                mBuffered = 1'b0;
            end
        end else if (!mOutstanding && !mBuffered) begin
            mOutstanding = 1'b1;
            mLive = 1'b1;
            mReqAddr = mExpPc;
        end else if (mOutstanding) begin
            if (rv) begin
                mOutstanding = 1'b0;
                if (mLive) begin
                    instQ.push_back('{addr: mReqAddr, data: rdata});
                    mBuffered = 1'b1;
                    mExpPc = mReqAddr + 16'd4;
                end
                mLive = 1'b0;
            end
        end else if (mBuffered && rdy) begin
            modelHandshakes++;
            mBuffered = 1'b0;
        end
    endtask

    // Monitor: compares what the DUT presents against the queued
    // expectations, and plays the memory side of each request it sees.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (imemReq === 1'b1) begin
                if (reqQ.size() == 0) begin
                    checkOutput("imem_req_unexpected", 64'(imemReq), 64'd0);
                end else begin
                    checkOutput("imem_addr", 64'(imemAddr), 64'(reqQ.pop_front()));
                end
                memCount = $urandom_range(cfgMaxLat, 1);
                memData = $urandom;
            end else if (reqQ.size() > 0) begin
                checkOutput("imem_req_missing", 64'(imemReq), 64'd1);
                void'(reqQ.pop_front());
            end
            checkOutput("PC", 64'(pcOut), 64'(expPcNow));
            checkOutput("inst_valid", 64'(instValid), 64'(expValidNow));
            if (instValid === 1'b1) begin
                if (instQ.size() == 0) begin
                    checkOutput("inst_valid_unexpected", 64'(instValid), 64'd0);
                end else begin
                    checkOutput("inst", 64'(instData), 64'(instQ[0].data));
                    checkOutput("inst_PC", 64'(instPc), 64'(instQ[0].addr));
                    if (instReady === 1'b1) begin
                        void'(instQ.pop_front());
                        handshakes++;
                    end
                end
            end
        end
    end

    // Test sequence: clean back-to-back fetches, an address wrap, then a
    // long randomized run with redirects, stalls, stray responses and resets.
    initial begin
        reset = 1'b1;
        redirectValid = 1'b0;
        redirectPc = '0;
        imemRvalid = 1'b0;
        imemRdata = '0;
        instReady = 1'b0;

        repeat (2) applyStimulus(1'b1);
        repeat (12) applyStimulus(1'b0);

        cfgForceTarget = 16'hFFFC;
        cfgForceRedirect = 1'b1;
        applyStimulus(1'b0);
        repeat (12) applyStimulus(1'b0);

        cfgRedirPct = 12;
        cfgMaxLat = 4;
        cfgReadyPct = 70;
        cfgSpurPct = 10;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(99) == 0);
        end

        cfgRedirPct = 0;
        cfgSpurPct = 0;
        cfgReadyPct = 100;
        repeat (10) applyStimulus(1'b0);

        @(negedge clock);
        #3;
        checkOutput("handshake_count", 64'(handshakes), 64'(modelHandshakes));
        checkOutput("handshakes_seen", 64'(handshakes > 100), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls instruction fetch. It owns the fetch PC and issues one request at a time to instruction memory. Each returned instruction is held in a one-entry output buffer with a valid/ready handshake to decode. Redirects from execute (branch or jump target) override sequential PC advance and squash any in-flight or buffered instruction.

Parameters:
ADDRESS_BITS, 16, width of all PC and address signals
DATA_WIDTH, 32, instruction width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, sequential PC increment

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
redirect_valid  input  1  execute requests PC redirect this cycle
redirect_PC  input  ADDRESS_BITS  redirect target
imem_req  output  1  one-cycle fetch request pulse
imem_addr  output  ADDRESS_BITS  fetch address, always equals PC
imem_rvalid  input  1  memory response valid, latency >=1 cycle after imem_req
imem_rdata  input  DATA_WIDTH  instruction data, valid with imem_rvalid
inst_valid  output  1  output buffer holds a valid instruction
inst  output  DATA_WIDTH  buffered instruction
inst_PC  output  ADDRESS_BITS  address of buffered instruction
inst_ready  input  1  decode accepts instruction
PC  output  ADDRESS_BITS  current fetch PC

Behaviour:
- Synchronous, active-high reset. On reset: state=ISSUE, PC=RESET_PC, inst_valid=0, inst=0, inst_PC=0. imem_req=0 in every cycle where reset=1.
- States:
  - ISSUE: emit request.
  - WAIT: request outstanding.
  - HOLD: buffer full.
  - DRAIN: outstanding response must be discarded.
- imem_req = (state==ISSUE) & ~redirect_valid & ~reset. imem_addr = PC combinationally.
- ISSUE:
  - No redirect: go to WAIT.
  - Redirect: PC<=redirect_PC, stay in ISSUE, no request is issued.
- WAIT:
  - imem_rvalid & ~redirect_valid: inst<=imem_rdata, inst_PC<=PC, inst_valid<=1, PC<=PC+PC_STEP, go to HOLD.
  - redirect_valid & imem_rvalid: discard data, PC<=redirect_PC, go to ISSUE.
  - redirect_valid & ~imem_rvalid: PC<=redirect_PC, go to DRAIN.
  - Neither: stay in WAIT.
- DRAIN:
  - imem_rvalid: discard, go to ISSUE.
  - Any redirect_valid here: PC<=redirect_PC, most recent redirect wins.
- HOLD (inst_valid=1):
  - inst_valid & inst_ready is a completed handshake, including in the same cycle as a redirect.
  - Handshake and no redirect: inst_valid<=0, go to ISSUE.
  - redirect_valid (with or without handshake): inst_valid<=0, PC<=redirect_PC, go to ISSUE.
  - Otherwise inst, inst_PC and inst_valid stay stable.
- Single outstanding request. imem_rvalid in ISSUE or HOLD is a protocol error and is ignored without corrupting state.
- PC arithmetic is modulo 2^ADDRESS_BITS; FFFC+4 wraps to 0000. No alignment check on redirect_PC.
- Throughput: 3 cycles per instruction with latency-1 memory and inst_ready held high.

Decomposition:
- Package fetch_pkg:
  - state enum {ISSUE, WAIT, HOLD, DRAIN}, 2-bit encoding.
  - PC_STEP default constant.
- No sub-module. The PC register and output buffer are simple enough to inline.
- The existing fetch block is not instantiated; this block supersedes its next_PC_select/target_PC interface with redirect_valid/redirect_PC.

Test Plan:
- Reset release, memory latency 1, inst_ready=1 -> imem_req at cycles 0/3/6 with addr 0000/0004/0008; inst_valid at cycles 2/5/8 with inst_PC 0000/0004/0008.
- inst_ready=0 for 4 cycles while in HOLD -> inst, inst_PC stable; no imem_req; PC=0004. inst_ready=1 -> next cycle imem_req addr 0004.
- Redirect to 0051 in WAIT, memory latency 3 -> DRAIN; stale data discarded, no inst_valid. Next request addr 0051, then inst_PC 0051 and PC 0055.
- Redirect to 0012 in HOLD with inst_ready=1 -> handshake counted; next cycle inst_valid=0 and imem_req addr 0012. Redirect 0016 on the same cycle as imem_rvalid in WAIT -> data dropped, next request addr 0016.
- PC at FFFC, fetch completes -> PC=0000. Reset asserted in WAIT -> next cycle PC=RESET_PC, inst_valid=0, state ISSUE. A late imem_rvalid in ISSUE is ignored.
